frv_lfsr32_check: RTL and testbench

- Consumer-side checker for the 32-bit XNOR-tap PRNG stream used across the core (masking and randomised-execution sources).
- Observes each published PRNG word together with the extra tap bit that produced it, and locks onto the sequence.
- Predicts every following word and flags divergence, lock-up and repeated-seed faults.
- Sits beside the PRNG as a health monitor; its alarm feeds the core's fault/trap logic.

---
 rtl/frv_lfsr32_check_pkg.sv | 18 +
 rtl/frv_lfsr32_pred.sv | 13 +
 rtl/frv_lfsr32_check.sv | 141 ++++++++++++++
 tb/tb_frv_lfsr32_check.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/frv_lfsr32_check_pkg.sv
// Shared definitions for the 32-bit XNOR-tap PRNG stream: state encoding,
// lock-up word and the single feedback definition used by producers and checkers.
package frv_lfsr32_check_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // All-ones is the XNOR lock-up word: with tap = 0 its successor is itself.
   localparam logic [31:0] LOCKUP_WORD = 32'hFFFF_FFFF;

   function automatic logic lfsr_fb(input logic [31:0] p, input logic t);
      return ~(p[31] ^ p[21] ^ p[1] ^ p[0]) ^ t;
   endfunction

endpackage

// File: rtl/frv_lfsr32_pred.sv
// Combinational next-word predictor for the XNOR-tap PRNG: shifts the previous
// word left and inserts the feedback bit (including the extra tap).
module frv_lfsr32_pred
   import frv_lfsr32_check_pkg::*;
(
   input  logic [31:0] i_p,
   input  logic        i_t,
   output logic [31:0] o_pred
);

   assign o_pred = {i_p[30:0], lfsr_fb(i_p, i_t)};

endmodule

// File: rtl/frv_lfsr32_check.sv
// PRNG stream health monitor: locks onto the observed sequence, predicts each
// following word and raises sticky alarms on lost lock or the lock-up word.
module frv_lfsr32_check
   import frv_lfsr32_check_pkg::*;
#(
   parameter int LOCK_CNT  = 4,
   parameter int ERR_LIMIT = 3,
   parameter int ERR_W     = 8
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             in_valid,
   input  logic [31:0]      in_prng,
   input  logic             in_tap,
   input  logic             clear,
   output logic             locked,
   output logic             mismatch,
   output logic             stuck,
   output logic             alarm,
   output logic [ERR_W-1:0] err_count
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(ERR_LIMIT + 1);

   state_e             r_state,    w_state_nxt;
   logic [31:0]        r_last,     w_last_nxt;
   logic [GOOD_W-1:0]  r_good,     w_good_nxt;
   logic [BAD_W-1:0]   r_bad,      w_bad_nxt;
   logic [ERR_W-1:0]   r_err,      w_err_nxt;
   logic               r_mismatch, w_mismatch_nxt;
   logic               r_stuck,    w_stuck_nxt;
   logic               r_alarm,    w_alarm_nxt;

   logic [31:0]        w_pred;
   logic               w_match;

   frv_lfsr32_pred u_pred (
      .i_p    (r_last),
      .i_t    (in_tap),
      .o_pred (w_pred)
   );

   assign w_match = (in_prng == w_pred);

   // NOTE: every next-value is defaulted to its current value first so that no
   // path through the decode below leaves a signal unassigned and infers a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_nxt     = r_last;
      w_good_nxt     = r_good;
      w_bad_nxt      = r_bad;
      w_err_nxt      = r_err;
      w_mismatch_nxt = 1'b0;
      w_stuck_nxt    = r_stuck;
      w_alarm_nxt    = r_alarm;

      if (clear) begin
         w_state_nxt = ST_HUNT;
         w_good_nxt  = '0;
         w_bad_nxt   = '0;
         w_err_nxt   = '0;
         w_stuck_nxt = 1'b0;
         w_alarm_nxt = 1'b0;
      end else if (in_valid) begin
         if (in_prng == LOCKUP_WORD) begin
            w_stuck_nxt = 1'b1;
            w_alarm_nxt = 1'b1;
         end
         case (r_state)
            ST_HUNT: begin
               w_last_nxt  = in_prng;
               w_good_nxt  = '0;
               w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
               w_last_nxt = in_prng;
               if (w_match) begin
                  w_good_nxt = r_good + 1'b1;
                  if (r_good == GOOD_W'(LOCK_CNT - 1)) begin
                     w_state_nxt = ST_LOCKED;
                     w_bad_nxt   = '0;
                  end
               end else begin
                  w_good_nxt = '0;
               end
            end
            ST_LOCKED: begin
               if (w_match) begin
                  w_bad_nxt  = '0;
                  w_last_nxt = in_prng;
               end else begin
                  // Keep following our own prediction rather than the bad word.
                  w_last_nxt     = w_pred;
                  w_mismatch_nxt = 1'b1;
                  if (r_err != {ERR_W{1'b1}}) w_err_nxt = r_err + 1'b1;
                  if (r_bad == BAD_W'(ERR_LIMIT - 1)) begin
                     w_alarm_nxt = 1'b1;
                     w_state_nxt = ST_HUNT;
                     w_bad_nxt   = '0;
                  end else begin
                     w_bad_nxt = r_bad + 1'b1;
                  end
               end
            end
            default: w_state_nxt = ST_HUNT;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state    <= ST_HUNT;
         r_last     <= '0;
         r_good     <= '0;
         r_bad      <= '0;
         r_err      <= '0;
         r_mismatch <= 1'b0;
         r_stuck    <= 1'b0;
         r_alarm    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_good     <= w_good_nxt;
         r_bad      <= w_bad_nxt;
         r_err      <= w_err_nxt;
         r_mismatch <= w_mismatch_nxt;
         r_stuck    <= w_stuck_nxt;
         r_alarm    <= w_alarm_nxt;
      end
   end

   assign locked    = (r_state == ST_LOCKED);
   assign mismatch  = r_mismatch;
   assign stuck     = r_stuck;
   assign alarm     = r_alarm;
   assign err_count = r_err;

endmodule

// File: tb/tb_frv_lfsr32_check.sv
// Directed, table-driven bench for frv_lfsr32_check using a hand-computed
// tap-0 stream plus hand-written reset, saturation and re-hunt sequences.
module tb_frv_lfsr32_check;

   logic        g_clk;
   logic        g_resetn;
   logic        in_valid;
   logic [31:0] in_prng;
   logic        in_tap;
   logic        clear;
   logic        locked;
   logic        mismatch;
   logic        stuck;
   logic        alarm;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        valid;
      logic [31:0] word;
      logic        tap;
      logic        clr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Hand-computed tap-0 stream starting at 0x6789ABCD.
   localparam logic [31:0] W0  = 32'h6789ABCD;
   localparam logic [31:0] W1  = 32'hCF13579A;
   localparam logic [31:0] W2  = 32'h9E26AF35;
   localparam logic [31:0] W3  = 32'h3C4D5E6A;
   localparam logic [31:0] W4  = 32'h789ABCD4;
   localparam logic [31:0] W5  = 32'hF13579A9;
   localparam logic [31:0] W6  = 32'hE26AF352;
   localparam logic [31:0] W7  = 32'hC4D5E6A4;
   localparam logic [31:0] W8  = 32'h89ABCD48;
   localparam logic [31:0] W9  = 32'h13579A91;
   localparam logic [31:0] W10 = 32'h26AF3522;
   // Stream from W0 with tap = 1 on the first step, tap = 0 afterwards.
   localparam logic [31:0] V1  = 32'hCF13579B;
   localparam logic [31:0] V2  = 32'h9E26AF36;
   localparam logic [31:0] V3  = 32'h3C4D5E6C;
   localparam logic [31:0] V4  = 32'h789ABCD9;
   localparam logic [31:0] V5  = 32'hF13579B2;

   frv_lfsr32_check dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .in_valid  (in_valid),
      .in_prng   (in_prng),
      .in_tap    (in_tap),
      .clear     (clear),
      .locked    (locked),
      .mismatch  (mismatch),
      .stuck     (stuck),
      .alarm     (alarm),
      .err_count (err_count)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   function automatic logic [31:0] ex(input logic l, input logic m, input logic s,
                                      input logic a, input logic [7:0] e);
      return {20'd0, l, m, s, a, e};
   endfunction

   function automatic logic [31:0] outs();
      return {20'd0, locked, mismatch, stuck, alarm, err_count};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (locked,mismatch,stuck,alarm,err)", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] w, input logic t, input logic c);
      in_valid = v;
      in_prng  = w;
      in_tap   = t;
      clear    = c;
      @(posedge g_clk);
      #1;
   endtask

   task automatic add(input logic v, input logic [31:0] w, input logic t, input logic c,
                      input logic [31:0] e);
      vec_t x;
      x.valid = v; x.word = w; x.tap = t; x.clr = c; x.exp = e;
      tbl.push_back(x);
   endtask

   initial begin
      in_valid = 1'b0; in_prng = '0; in_tap = 1'b0; clear = 1'b0;
      g_resetn = 1'b0;

      // Lock on a clean stream: locked after the 5th valid word.
      add(1, W0, 0, 0, ex(0,0,0,0,0));
      add(1, W1, 0, 0, ex(0,0,0,0,0));
      add(1, W2, 0, 0, ex(0,0,0,0,0));
      add(1, W3, 0, 0, ex(0,0,0,0,0));
      add(1, W4, 0, 0, ex(1,0,0,0,0));
      add(0, 0,  0, 0, ex(1,0,0,0,0));
      add(1, W5, 0, 0, ex(1,0,0,0,0));
      // Single corruption, then recovery on the predicted word.
      add(1, W6 ^ 32'h1, 0, 0, ex(1,1,0,0,1));
      add(1, W7, 0, 0, ex(1,0,0,0,1));
      add(0, 0,  0, 0, ex(1,0,0,0,1));
      // Two misses, a match (bad count clears), then three misses lose lock.
      add(1, 32'h0, 0, 0, ex(1,1,0,0,2));
      add(1, 32'h0, 0, 0, ex(1,1,0,0,3));
      add(1, W10,   0, 0, ex(1,0,0,0,3));
      add(1, 32'h12345678, 0, 0, ex(1,1,0,0,4));
      add(1, 32'h12345678, 0, 0, ex(1,1,0,0,5));
      add(1, 32'h12345678, 0, 0, ex(0,1,0,1,6));
      add(0, 0,  0, 0, ex(0,0,0,1,6));
      // Re-hunt and re-lock; alarm stays sticky.
      add(1, W0, 0, 0, ex(0,0,0,1,6));
      add(1, W1, 0, 0, ex(0,0,0,1,6));
      add(1, W2, 0, 0, ex(0,0,0,1,6));
      add(1, W3, 0, 0, ex(0,0,0,1,6));
      add(1, W4, 0, 0, ex(1,0,0,1,6));
      // Clear with a valid word: the word is dropped, W6 becomes the seed.
      add(1, W5, 0, 1, ex(0,0,0,0,0));
      add(1, W6, 0, 0, ex(0,0,0,0,0));
      add(1, W7, 0, 0, ex(0,0,0,0,0));
      add(1, W8, 0, 0, ex(0,0,0,0,0));
      add(1, W9, 0, 0, ex(0,0,0,0,0));
      add(1, W10,0, 0, ex(1,0,0,0,0));
      // Extra tap honoured: V1 with tap = 1 is a match.
      add(0, 0,  0, 1, ex(0,0,0,0,0));
      add(1, W0, 0, 0, ex(0,0,0,0,0));
      add(1, V1, 1, 0, ex(0,0,0,0,0));
      add(1, V2, 0, 0, ex(0,0,0,0,0));
      add(1, V3, 0, 0, ex(0,0,0,0,0));
      add(1, V4, 0, 0, ex(1,0,0,0,0));
      // Same word with tap = 0 is a silent SYNC miss.
      add(0, 0,  0, 1, ex(0,0,0,0,0));
      add(1, W0, 0, 0, ex(0,0,0,0,0));
      add(1, V1, 0, 0, ex(0,0,0,0,0));
      add(1, V2, 0, 0, ex(0,0,0,0,0));
      add(1, V3, 0, 0, ex(0,0,0,0,0));
      add(1, V4, 0, 0, ex(0,0,0,0,0));
      add(1, V5, 0, 0, ex(1,0,0,0,0));
      // Lock-up word: stuck and alarm are sticky until clear.
      add(0, 0,  0, 1, ex(0,0,0,0,0));
      add(1, 32'hFFFFFFFF, 0, 0, ex(0,0,1,1,0));
      add(0, 0,  0, 0, ex(0,0,1,1,0));
      add(0, 0,  0, 1, ex(0,0,0,0,0));

      repeat (2) @(posedge g_clk);
      #1;
      check("reset_state", outs(), ex(0,0,0,0,0));
      @(negedge g_clk);
      g_resetn = 1'b1;
      @(posedge g_clk);
      #1;
      check("after_release", outs(), ex(0,0,0,0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].valid, tbl[i].word, tbl[i].tap, tbl[i].clr);
         check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // Error counter saturation: 86 rounds of lock + three misses.
      step(0, 0, 0, 1);
      for (int r = 0; r < 86; r++) begin
         step(1, W0, 0, 0);
         step(1, W1, 0, 0);
         step(1, W2, 0, 0);
         step(1, W3, 0, 0);
         step(1, W4, 0, 0);
         step(1, 32'h0, 0, 0);
         step(1, 32'h0, 0, 0);
         step(1, 32'h0, 0, 0);
         if (r == 84) check("err_reach_max", outs(), ex(0,1,0,1,8'hFF));
         if (r == 85) check("err_saturated", outs(), ex(0,1,0,1,8'hFF));
      end

      // Re-lock, then assert reset asynchronously between edges.
      step(1, W0, 0, 0);
      step(1, W1, 0, 0);
      step(1, W2, 0, 0);
      step(1, W3, 0, 0);
      step(1, W4, 0, 0);
      check("relock_before_reset", outs(), ex(1,0,0,1,8'hFF));
      in_valid = 1'b0;
      #2;
      g_resetn = 1'b0;
      #1;
      check("async_reset", outs(), ex(0,0,0,0,0));
      @(negedge g_clk);
      g_resetn = 1'b1;

      // Must re-hunt: W5 seeds, lock after the 5th valid word.
      step(1, W5, 0, 0);
      step(1, W6, 0, 0);
      step(1, W7, 0, 0);
      step(1, W8, 0, 0);
      check("rehunt_not_yet", outs(), ex(0,0,0,0,0));
      step(1, W9, 0, 0);
      check("rehunt_locked", outs(), ex(1,0,0,0,0));
      step(0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
